// File: rtl/perf_mon_pkg.sv
// Shared definitions for the retirement / performance monitor.
//   state_t        : monitor FSM states
//   OPC_SYSTEM     : major opcode of SYSTEM instructions (CSR accesses)
//   F3_CSRRW       : funct3 of CSRRW, the end-of-test marker write
//   is_eot_trigger : decodes an exec0 opcode beat as the end-of-test write
package perf_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_TIMEOUT
   } state_t;

   localparam logic [6:0] OPC_SYSTEM = 7'h73;
   localparam logic [2:0] F3_CSRRW   = 3'b001;

   // Only the major opcode and funct3 identify CSRRW. The CSR address and
   // registers are irrelevant because any CSRRW ends the test.
   function automatic logic is_eot_trigger(input logic       valid,
                                           input logic [6:0] opcode,
                                           input logic [2:0] funct3);
      return valid && (opcode == OPC_SYSTEM) && (funct3 == F3_CSRRW);
   endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter that advances by 0, 1 or 2 per enabled edge.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear to zero
//   en    : advance by inc on this edge
//   inc   : increment amount (0..2)
//   count : current value, sticks at all-ones
module perf_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       inc,
   output logic [CNT_W-1:0] count
);

   // One spare bit catches a carry out. Because count <= all-ones and
   // inc <= 2, a set carry bit means the true sum exceeds the maximum.
   logic [CNT_W:0] sum;

   assign sum = {1'b0, count} + {{(CNT_W - 1){1'b0}}, inc};

   // NOTE: registered state is assigned with <= so every flop samples
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/retire_perf_monitor.sv
// Retirement and performance monitor for the dual-issue core.
// It counts cycles and retired instructions from the enable edge until an
// end-of-test CSRRW. After that, it waits DRAIN_CYCLES more counted cycles
// so trailing stores land, then freezes the counters and reports done.
// A cycle watchdog reports timeout if the marker never arrives.
//   clk_i            : clock, rising edge
//   rst_ni           : synchronous active-low reset
//   clear_i          : synchronous soft clear back to IDLE
//   enable_i         : start counting (sampled in IDLE)
//   pipe0_valid_wb_i : pipe0 retired an instruction this cycle
//   pipe1_valid_wb_i : pipe1 retired an instruction this cycle
//   opcode_valid_i   : exec0 opcode beat valid
//   opcode_opcode_i  : exec0 instruction word
//   cycle_count_o    : counted cycles (saturating)
//   instr_count_o    : retired instructions (saturating)
//   busy_o           : counting (RUN or DRAIN)
//   done_o           : end-of-test seen and drain finished
//   timeout_o        : watchdog fired
module retire_perf_monitor
   import perf_mon_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int DRAIN_CYCLES   = 10,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic             pipe0_valid_wb_i,
   input  logic             pipe1_valid_wb_i,
   input  logic             opcode_valid_i,
   input  logic [31:0]      opcode_opcode_i,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic [CNT_W-1:0] instr_count_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
   // The watchdog looks one count ahead, so the edge that would display
   // TIMEOUT_CYCLES is the same edge that enters TIMEOUT.
   localparam logic [CNT_W-1:0] WATCHDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             state;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               counting;
   logic               trigger;
   logic               watchdog_hit;
   logic [1:0]         retire_inc;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   instr_count;
   logic               opcode_unused;

   assign counting     = (state == ST_RUN) || (state == ST_DRAIN);
   assign trigger      = is_eot_trigger(opcode_valid_i, opcode_opcode_i[6:0],
                                        opcode_opcode_i[14:12]);
   assign watchdog_hit = counting && (cycle_count == WATCHDOG_LAST);
   assign retire_inc   = {1'b0, pipe0_valid_wb_i} + {1'b0, pipe1_valid_wb_i};

   // Register and CSR fields of the instruction word do not affect the decode.
   assign opcode_unused = ^{opcode_opcode_i[31:15], opcode_opcode_i[11:7]};

   perf_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (clear_i),
      .en    (counting),
      .inc   (2'd1),
      .count (cycle_count)
   );

   perf_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (clear_i),
      .en    (counting),
      .inc   (retire_inc),
      .count (instr_count)
   );

   // The watchdog is tested first in RUN and DRAIN. It therefore wins over a
   // same-edge trigger and over a same-edge drain completion.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else if (clear_i) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable_i) state <= ST_RUN;
            end
            ST_RUN: begin
               if (watchdog_hit) begin
                  state <= ST_TIMEOUT;
               end else if (trigger) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               if (watchdog_hit) begin
                  state <= ST_TIMEOUT;
               end else if (drain_cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               // Terminal: only reset or clear_i leaves these states.
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cycle_count_o = cycle_count;
   assign instr_count_o = instr_count;
   assign busy_o        = counting;
   assign done_o        = (state == ST_DONE);
   assign timeout_o     = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Self-checking bench for retire_perf_monitor. Three configurations share one
// input stream. A per-cycle scoreboard compares every output against an
// event-based reference model, and directed checks cover the key scenarios.
module tb_retire_perf_monitor;

   localparam int N = 3;

   // Configurations: 0 = normal, 1 = short watchdog, 2 = 4-bit counters.
   function automatic int cfg_cw(input int k);
      return (k == 2) ? 4 : 32;
   endfunction
   function automatic longint cfg_drain(input int k);
      return (k == 2) ? 3 : 10;
   endfunction
   function automatic longint cfg_to(input int k);
      case (k)
         0:       return 50;
         1:       return 45;
         default: return 15;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        enable_i = 1'b0;
   logic        pipe0_valid_wb_i = 1'b0;
   logic        pipe1_valid_wb_i = 1'b0;
   logic        opcode_valid_i = 1'b0;
   logic [31:0] opcode_opcode_i = '0;

   logic [31:0]  act_cyc [N];
   logic [31:0]  act_ins [N];
   logic [N-1:0] act_busy, act_done, act_to;
   logic [3:0]   cyc_c, ins_c;

   assign act_cyc[2] = {28'd0, cyc_c};
   assign act_ins[2] = {28'd0, ins_c};

   always #5 clk = ~clk;

   retire_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(50)) dut_a (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
      .pipe0_valid_wb_i(pipe0_valid_wb_i), .pipe1_valid_wb_i(pipe1_valid_wb_i),
      .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
      .cycle_count_o(act_cyc[0]), .instr_count_o(act_ins[0]),
      .busy_o(act_busy[0]), .done_o(act_done[0]), .timeout_o(act_to[0]));

   retire_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(45)) dut_b (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
      .pipe0_valid_wb_i(pipe0_valid_wb_i), .pipe1_valid_wb_i(pipe1_valid_wb_i),
      .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
      .cycle_count_o(act_cyc[1]), .instr_count_o(act_ins[1]),
      .busy_o(act_busy[1]), .done_o(act_done[1]), .timeout_o(act_to[1]));

   retire_perf_monitor #(.CNT_W(4), .DRAIN_CYCLES(3), .TIMEOUT_CYCLES(15)) dut_c (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
      .pipe0_valid_wb_i(pipe0_valid_wb_i), .pipe1_valid_wb_i(pipe1_valid_wb_i),
      .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
      .cycle_count_o(cyc_c), .instr_count_o(ins_c),
      .busy_o(act_busy[2]), .done_o(act_done[2]), .timeout_o(act_to[2]));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode 0 idle, 1 counting, 2 done, 3 timeout. trig holds the cycle number
   // at which the end-of-test write was seen (-1 if none). Done is due when
   // the cycle count reaches trig + DRAIN.
   typedef struct {
      longint cyc;
      longint ins;
      bit     busy;
      bit     done;
      bit     tmo;
   } exp_t;

   int     m_mode [N];
   longint m_cyc  [N];
   longint m_ins  [N];
   longint m_trig [N];
   exp_t   exp_q [$];

   function automatic bit is_trig_word(input logic v, input logic [31:0] w);
      return v && (w[6:0] == 7'h73) && (w[14:12] == 3'b001);
   endfunction

   function automatic void model_step();
      bit trig_now;
      trig_now = is_trig_word(opcode_valid_i, opcode_opcode_i);
      for (int k = 0; k < N; k++) begin
         longint mx;
         exp_t   e;
         mx = (longint'(1) << cfg_cw(k)) - 1;
         if (!rst_ni || clear_i) begin
            m_mode[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_trig[k] = -1;
         end else if (m_mode[k] == 0) begin
            if (enable_i) m_mode[k] = 1;
         end else if (m_mode[k] == 1) begin
            m_cyc[k] = (m_cyc[k] + 1 > mx) ? mx : m_cyc[k] + 1;
            m_ins[k] = m_ins[k] + longint'(pipe0_valid_wb_i) + longint'(pipe1_valid_wb_i);
            if (m_ins[k] > mx) m_ins[k] = mx;
            if (m_cyc[k] == cfg_to(k)) m_mode[k] = 3;
            else if (m_trig[k] < 0) begin
               if (trig_now) m_trig[k] = m_cyc[k];
            end else if (m_cyc[k] == m_trig[k] + cfg_drain(k)) m_mode[k] = 2;
         end
         e.cyc  = m_cyc[k];
         e.ins  = m_ins[k];
         e.busy = (m_mode[k] == 1);
         e.done = (m_mode[k] == 2);
         e.tmo  = (m_mode[k] == 3);
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: outputs are registered, so each posedge yields one snapshot per
   // DUT. It is compared on the following falling edge.
   always @(negedge clk) begin
      while (exp_q.size() >= N) begin
         for (int k = 0; k < N; k++) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("dut%0d cycle_count", k), 64'(act_cyc[k]), 64'(e.cyc));
            check($sformatf("dut%0d instr_count", k), 64'(act_ins[k]), 64'(e.ins));
            check($sformatf("dut%0d busy", k), 64'(act_busy[k]), 64'(e.busy));
            check($sformatf("dut%0d done", k), 64'(act_done[k]), 64'(e.done));
            check($sformatf("dut%0d timeout", k), 64'(act_to[k]), 64'(e.tmo));
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam int OP_NONE = 0, OP_CSRRW = 1, OP_CSRRS = 2;

   task automatic set_op(input int kind);
      logic [31:0] w;
      w = $urandom;
      case (kind)
         OP_CSRRW: begin w[6:0] = 7'h73; w[14:12] = 3'b001; opcode_valid_i = 1'b1; end
         OP_CSRRS: begin w[6:0] = 7'h73; w[14:12] = 3'b010; opcode_valid_i = 1'b1; end
         default: begin
            if (w[6:0] == 7'h73 && w[14:12] == 3'b001) w[12] = 1'b0;
            opcode_valid_i = 1'($urandom_range(0, 1));
         end
      endcase
      opcode_opcode_i = w;
   endtask

   // Drive one cycle of inputs (at a falling edge), then let the clock
   // advance to the next falling edge while the model tracks the rising one.
   task automatic step(input bit rst, input bit en, input bit clr,
                       input bit v0, input bit v1, input int op);
      rst_ni           = ~rst;
      enable_i         = en;
      clear_i          = clr;
      pipe0_valid_wb_i = v0;
      pipe1_valid_wb_i = v1;
      set_op(op);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic do_clear();
      step(0, 0, 1, rb(), rb(), OP_NONE);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         m_mode[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_trig[k] = -1;
      end

      // Reset held for 3 cycles while retires and enable toggle.
      for (int i = 0; i < 3; i++) step(1, i[0], 0, rb(), rb(), OP_NONE);
      step(0, 0, 0, rb(), rb(), OP_NONE);
      for (int k = 0; k < N; k++) begin
         check($sformatf("reset dut%0d cycle", k), 64'(act_cyc[k]), 64'd0);
         check($sformatf("reset dut%0d instr", k), 64'(act_ins[k]), 64'd0);
         check($sformatf("reset dut%0d busy", k), 64'(act_busy[k]), 64'd0);
         check($sformatf("reset dut%0d done", k), 64'(act_done[k]), 64'd0);
         check($sformatf("reset dut%0d timeout", k), 64'(act_to[k]), 64'd0);
      end

      // Normal end-of-test: 20 dual retires, CSRRS ignored, CSRRW at cycle 21.
      step(0, 1, 0, 1, 1, OP_NONE);
      check("busy after enable", 64'(act_busy[0]), 64'd1);
      for (int i = 1; i <= 20; i++) step(0, 0, 0, 1, 1, (i == 5) ? OP_CSRRS : OP_NONE);
      step(0, 0, 0, 0, 0, OP_CSRRW);
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 0, 0, 0, (i == 2) ? OP_CSRRW : OP_NONE);
         if (i == 9) check("done low before drain ends", 64'(act_done[0]), 64'd0);
      end
      check("normal done", 64'(act_done[0]), 64'd1);
      check("normal cycle", 64'(act_cyc[0]), 64'd31);
      check("normal instr", 64'(act_ins[0]), 64'd40);
      check("normal timeout", 64'(act_to[0]), 64'd0);
      check("normal dut1 cycle", 64'(act_cyc[1]), 64'd31);
      for (int i = 0; i < 20; i++) step(0, rb(), 0, 1, 1, OP_CSRRW);
      check("frozen cycle", 64'(act_cyc[0]), 64'd31);
      check("frozen instr", 64'(act_ins[0]), 64'd40);
      check("frozen done", 64'(act_done[0]), 64'd1);
      do_clear();

      // Watchdog with no trigger.
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 0; i < 60; i++) step(0, 0, 0, rb(), rb(), OP_NONE);
      check("timeout flag", 64'(act_to[0]), 64'd1);
      check("timeout cycle", 64'(act_cyc[0]), 64'd50);
      check("timeout done", 64'(act_done[0]), 64'd0);
      do_clear();

      // CSRRW on the same edge the watchdog fires.
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 1; i <= 50; i++) step(0, 0, 0, rb(), rb(), (i == 50) ? OP_CSRRW : OP_NONE);
      for (int i = 0; i < 5; i++) step(0, 0, 0, rb(), rb(), OP_NONE);
      check("simul timeout", 64'(act_to[0]), 64'd1);
      check("simul done", 64'(act_done[0]), 64'd0);
      check("simul cycle", 64'(act_cyc[0]), 64'd50);
      do_clear();

      // Trigger at cycle 40: watchdog 45 fires at DRAIN cycle 5, and
      // watchdog 50 beats the drain completion on its final edge.
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 1; i <= 55; i++) step(0, 0, 0, rb(), rb(), (i == 40) ? OP_CSRRW : OP_NONE);
      check("drain wd45 timeout", 64'(act_to[1]), 64'd1);
      check("drain wd45 cycle", 64'(act_cyc[1]), 64'd45);
      check("drain wd45 done", 64'(act_done[1]), 64'd0);
      check("drain wd50 timeout", 64'(act_to[0]), 64'd1);
      check("drain wd50 done", 64'(act_done[0]), 64'd0);
      do_clear();

      // Saturation on the 4-bit configuration.
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, OP_NONE);
      check("sat instr", 64'(act_ins[2]), 64'd15);
      check("sat cycle", 64'(act_cyc[2]), 64'd10);
      check("sat busy", 64'(act_busy[2]), 64'd1);
      do_clear();

      // Clear in DRAIN cycle 3, then a fresh complete run.
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 1; i <= 5; i++) step(0, 0, 0, rb(), rb(), OP_NONE);
      step(0, 0, 0, 1, 0, OP_CSRRW);
      step(0, 0, 0, rb(), rb(), OP_NONE);
      step(0, 0, 0, rb(), rb(), OP_NONE);
      step(0, 0, 1, rb(), rb(), OP_NONE);
      check("clear busy", 64'(act_busy[0]), 64'd0);
      check("clear cycle", 64'(act_cyc[0]), 64'd0);
      check("clear instr", 64'(act_ins[0]), 64'd0);
      check("clear done", 64'(act_done[0]), 64'd0);
      step(0, 1, 0, 0, 0, OP_NONE);
      for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 1, OP_NONE);
      step(0, 0, 0, 1, 1, OP_CSRRW);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, OP_NONE);
      check("rerun done", 64'(act_done[0]), 64'd1);
      check("rerun cycle", 64'(act_cyc[0]), 64'd19);
      check("rerun instr", 64'(act_ins[0]), 64'd18);

      // Random episodes checked by the scoreboard only.
      for (int ep = 0; ep < 8; ep++) begin
         int len;
         do_clear();
         step(0, 1, 0, rb(), rb(), OP_NONE);
         len = $urandom_range(20, 70);
         for (int i = 0; i < len; i++) begin
            int r;
            int op;
            r  = $urandom_range(0, 99);
            op = (r < 5) ? OP_CSRRW : ((r < 10) ? OP_CSRRS : OP_NONE);
            step(($urandom_range(0, 199) == 0), rb(), ($urandom_range(0, 99) == 0),
                 rb(), rb(), op);
         end
      end

      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
